// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit: FSM states, instruction lengths,
// performance-counter width and the saturating increment helper.
package fetch_pkg;

   // Front-end control states.
   // RST_VEC and INT_VEC each spend one cycle reading a vector from memory.
   typedef enum logic [1:0] {
      RST_VEC = 2'd0,
      RUN     = 2'd1,
      INT_VEC = 2'd2
   } fetch_state_t;

   // Instruction lengths in memory words.
   localparam int ILEN_1 = 1;
   localparam int ILEN_2 = 2;

   // Width of the optional performance counters.
   localparam int CNT_WIDTH = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
      return (value == {CNT_WIDTH{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage : fetch_pkg

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch/stall event counters for the fetch unit.
// This block is only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt
   import fetch_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run_cycle,
   input  logic                 stall_cycle,
   output logic [CNT_WIDTH-1:0] fetch_cnt,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   // Count useful fetch cycles and stall cycles.
   // Each counter sticks at its maximum value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (run_cycle) begin
            fetch_cnt <= sat_inc(fetch_cnt);
         end
         if (stall_cycle) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
      end
   end

endmodule : fetch_perf_cnt

// File: rtl/fetch_unit.sv
// PC generation and fetch control for the pipeline front end.
// Features:
//   - loads the reset and interrupt vectors from instruction memory
//   - sequential fetch of one- or two-word instructions
//   - branch redirects
//   - interrupt request/acknowledge with a saved return PC
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH       = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int RESET_VEC_ADDR = 0,
   parameter int INTR_VEC_ADDR  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  f_stall,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  imm_en,
   input  logic                  branch_taken,
   input  logic [PC_WIDTH-1:0]   branch_target,
   input  logic                  intr_req,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  fetch_valid,
   output logic                  intr_ack,
   output logic [PC_WIDTH-1:0]   ret_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  fetch_cnt,
   output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

   fetch_state_t          state, state_nxt;
   logic [PC_WIDTH-1:0]   pc_nxt;
   logic [PC_WIDTH-1:0]   ret_pc_nxt;
   logic                  intr_ack_nxt;
   logic [PC_WIDTH-1:0]   seq_pc;
   logic [PC_WIDTH-1:0]   run_pc;

   // Address of the following instruction.
   // The adder wraps modulo 2^PC_WIDTH.
   always_comb begin
      seq_pc = pc + PC_WIDTH'(imm_en ? ILEN_2 : ILEN_1);
      run_pc = branch_taken ? branch_target : seq_pc;
   end

   // Next-state, next-PC and acknowledge decode.
   // A stall leaves every default in place.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nxt    = state;
      pc_nxt       = pc;
      ret_pc_nxt   = ret_pc;
      intr_ack_nxt = 1'b0;
      if (!f_stall) begin
         unique case (state)
            RST_VEC,
            INT_VEC: begin
               pc_nxt    = mem_data[PC_WIDTH-1:0];
               state_nxt = RUN;
            end
            RUN: begin
               if (intr_req) begin
                  // A branch taken in the same cycle survives as the return address.
                  ret_pc_nxt   = run_pc;
                  pc_nxt       = PC_WIDTH'(INTR_VEC_ADDR);
                  state_nxt    = INT_VEC;
                  intr_ack_nxt = 1'b1;
               end else begin
                  pc_nxt = run_pc;
               end
            end
            default: begin
               state_nxt = RST_VEC;
               pc_nxt    = PC_WIDTH'(RESET_VEC_ADDR);
            end
         endcase
      end
   end

   // State, PC, return PC and acknowledge registers.
   // Reset is synchronous and overrides every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples pre-edge values.
      if (!reset) begin
         state    <= RST_VEC;
         pc       <= PC_WIDTH'(RESET_VEC_ADDR);
         ret_pc   <= '0;
         intr_ack <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         ret_pc   <= ret_pc_nxt;
         intr_ack <= intr_ack_nxt;
      end
   end

   assign fetch_valid = (state == RUN);

`ifdef FETCH_PERF_CNT_EN
   fetch_perf_cnt u_perf_cnt (
      .clk         (clk),
      .reset       (reset),
      .run_cycle   ((state == RUN) && !f_stall),
      .stall_cycle (f_stall),
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
   );
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// The reference model tracks the PC with plain arithmetic and a
// "vector pending" flag. It covers the directed scenarios and a randomized run.
// Define FETCH_PERF_CNT_EN to also check the counters.
module tb_fetch_unit;

   localparam int PW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          f_stall;
   logic [DW-1:0] mem_data;
   logic          imm_en;
   logic          branch_taken;
   logic [PW-1:0] branch_target;
   logic          intr_req;
   logic [PW-1:0] pc;
   logic          fetch_valid;
   logic          intr_ack;
   logic [PW-1:0] ret_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0]   fetch_cnt;
   logic [15:0]   stall_cnt;
`endif

   logic [DW-1:0] mem [256];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int  m_pc;
   int  m_ret;
   bit  m_ack;
   bit  m_vec_pending;   // 1 while the next edge reads a vector
   int  m_fcnt;
   int  m_scnt;

   always #5 clk = ~clk;

   assign mem_data = mem[pc];

   fetch_unit #(
      .PC_WIDTH       (PW),
      .DATA_WIDTH     (DW),
      .RESET_VEC_ADDR (0),
      .INTR_VEC_ADDR  (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .f_stall       (f_stall),
      .mem_data      (mem_data),
      .imm_en        (imm_en),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .intr_req      (intr_req),
      .pc            (pc),
      .fetch_valid   (fetch_valid),
      .intr_ack      (intr_ack),
      .ret_pc        (ret_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt     (fetch_cnt),
      .stall_cnt     (stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle:
   //   1. drive the inputs,
   //   2. advance the model from the pre-edge values,
   //   3. compare all outputs shortly after the edge.
   task automatic step(input bit rst_v, input bit stall, input bit imm, input bit br,
                       input int tgt, input bit irq);
      int nxt;
      @(negedge clk);
      reset         = rst_v;
      f_stall       = stall;
      imm_en        = imm;
      branch_taken  = br;
      branch_target = PW'(tgt);
      intr_req      = irq;
      @(posedge clk);
      #1;
      m_ack = 0;
      if (!rst_v) begin
         m_pc = 0; m_ret = 0; m_vec_pending = 1; m_fcnt = 0; m_scnt = 0;
      end else begin
         if (stall) begin
            if (m_scnt < 16'hFFFF) m_scnt++;
         end else if (m_vec_pending) begin
            m_pc = int'(mem[m_pc]);
            m_vec_pending = 0;
         end else begin
            if (m_fcnt < 16'hFFFF) m_fcnt++;
            nxt = br ? tgt : (m_pc + (imm ? 2 : 1)) % 256;
            if (irq) begin
               m_ret = nxt; m_pc = 1; m_vec_pending = 1; m_ack = 1;
            end else begin
               m_pc = nxt;
            end
         end
      end
      check("pc", 32'(pc), 32'(m_pc));
      check("fetch_valid", 32'(fetch_valid), 32'(!m_vec_pending));
      check("intr_ack", 32'(intr_ack), 32'(m_ack));
      check("ret_pc", 32'(ret_pc), 32'(m_ret));
`ifdef FETCH_PERF_CNT_EN
      check("fetch_cnt", 32'(fetch_cnt), 32'(m_fcnt));
      check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`endif
   endtask

   initial begin
      int acks;
      bit irq_hold;
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 255));
      mem[0] = 8'h10;
      mem[1] = 8'h80;
      reset = 0; f_stall = 0; imm_en = 0; branch_taken = 0; branch_target = '0; intr_req = 0;
      m_pc = 0; m_ret = 0; m_ack = 0; m_vec_pending = 1; m_fcnt = 0; m_scnt = 0;

      // Reset with noise on the inputs: reset must win.
      step(0, 0, 1, 1, 8'h77, 1);
      step(0, 0, 0, 0, 0, 0);
      check("reset_pc", 32'(pc), 32'h00);
      check("reset_valid", 32'(fetch_valid), 32'h0);

      // Reset vector load.
      step(1, 0, 0, 0, 0, 0);
      check("rstvec_pc", 32'(pc), 32'h10);
      check("rstvec_valid", 32'(fetch_valid), 32'h1);

      // Sequential fetch with imm_en pattern 0,1,0.
      step(1, 0, 0, 0, 0, 0); check("seq1", 32'(pc), 32'h11);
      step(1, 0, 1, 0, 0, 0); check("seq2", 32'(pc), 32'h13);
      step(1, 0, 0, 0, 0, 0); check("seq3", 32'(pc), 32'h14);

      // Wrap: 0xFF + 2 -> 0x01.
      step(1, 0, 0, 1, 8'hFF, 0);
      step(1, 0, 1, 0, 0, 0); check("wrap", 32'(pc), 32'h01);

      // Stall holds a pending branch.
      step(1, 0, 0, 1, 8'h20, 0);
      step(1, 1, 0, 1, 8'h40, 0); check("stall_hold", 32'(pc), 32'h20);
      step(1, 0, 0, 1, 8'h40, 0); check("stall_release", 32'(pc), 32'h40);

      // Interrupt entry with intr_req held one extra cycle.
      step(1, 0, 0, 1, 8'h30, 0);
      acks = 0;
      step(1, 0, 1, 0, 0, 1);
      acks += int'(intr_ack);
      check("intr_ret", 32'(ret_pc), 32'h32);
      check("intr_vecpc", 32'(pc), 32'h01);
      step(1, 0, 0, 0, 0, 1);
      acks += int'(intr_ack);
      check("intr_target", 32'(pc), 32'h80);
      step(1, 0, 0, 0, 0, 0);
      acks += int'(intr_ack);
      check("single_ack", 32'(acks), 32'd1);

      // Branch and interrupt together, then reset during INT_VEC.
      step(1, 0, 0, 1, 8'h55, 1); check("br_intr_ret", 32'(ret_pc), 32'h55);
      step(0, 0, 0, 0, 0, 0);
      check("rst_in_intvec", 32'(pc), 32'h00);
      check("rst_in_intvec_ack", 32'(intr_ack), 32'h0);

      // Randomized run.
      // The requester holds intr_req until it sees the acknowledge.
      irq_hold = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!irq_hold && ($urandom_range(0, 9) == 0)) irq_hold = 1;
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0), 1'($urandom),
              ($urandom_range(0, 5) == 0), int'($urandom_range(0, 255)), irq_hold);
         if (intr_ack) irq_hold = 0;
      end

`ifdef FETCH_PERF_CNT_EN
      // Counters: 5 run cycles followed by 3 stall cycles.
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);   // vector load, not counted as a fetch
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
      check("fetch_cnt_5", 32'(fetch_cnt), 32'd5);
      check("stall_cnt_3", 32'(stall_cnt), 32'd3);
      // Drive the stall counter into saturation.
      for (int i = 0; i < 65540; i++) step(1, 1, 0, 0, 0, 0);
      check("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised PC-generation and fetch-control block for the pipeline front end, the next generation of the 8-bit fetch stage. It adds configurable PC/data widths, a vector-load FSM that reads the reset and interrupt vectors from instruction memory, an interrupt request/acknowledge handshake, and a saved return PC. It drives the instruction-memory address and takes redirects from the execute/branch stage.

Parameters:
PC_WIDTH, 8, width of pc, branch_target, ret_pc.
DATA_WIDTH, 8, width of the instruction-memory read bus; must be >= PC_WIDTH.
RESET_VEC_ADDR, 0, memory address holding the reset vector.
INTR_VEC_ADDR, 1, memory address holding the interrupt vector.

Ports:
clk  input  1  clock, all state on rising edge.
reset  input  1  synchronous active-low reset (asserted when 0).
f_stall  input  1  hold pc and FSM state this cycle.
mem_data  input  DATA_WIDTH  instruction-memory read data at address pc, combinational same cycle.
imm_en  input  1  current instruction is two words (opcode + immediate).
branch_taken  input  1  redirect request.
branch_target  input  PC_WIDTH  redirect address.
intr_req  input  1  level interrupt request; requester holds it until intr_ack.
pc  output  PC_WIDTH  instruction-memory address.
fetch_valid  output  1  pc addresses a real instruction (state RUN).
intr_ack  output  1  one-cycle pulse on interrupt acceptance.
ret_pc  output  PC_WIDTH  return address captured at interrupt entry.

Behaviour:
- Reset (reset==0 at a clock edge): state=RST_VEC, pc=RESET_VEC_ADDR, ret_pc=0, intr_ack=0. Reset overrides every other input.
- fetch_valid is combinational: 1 only in state RUN.
- States: RST_VEC, RUN, INT_VEC. f_stall=1 freezes state, pc and ret_pc in every state; intr_ack=0 while stalled.
- RST_VEC: next edge without stall loads pc <= mem_data[PC_WIDTH-1:0] and moves to RUN.
- INT_VEC: same as RST_VEC: pc <= mem_data[PC_WIDTH-1:0], then RUN. intr_req and branch_taken are ignored in RST_VEC and INT_VEC.
- RUN, not stalled: next = branch_taken ? branch_target : pc + (imm_en ? 2 : 1).
- RUN, not stalled, intr_req=1: ret_pc <= next, pc <= INTR_VEC_ADDR, state=INT_VEC, intr_ack=1 for that one cycle (registered). Branch and interrupt in the same cycle: the branch is honoured through ret_pc=branch_target.
- RUN, not stalled, intr_req=0: pc <= next.
- intr_req still high one cycle after intr_ack is not retaken until the FSM is back in RUN.
- Arithmetic: pc+1 and pc+2 are unsigned, wrapping modulo 2^PC_WIDTH (8-bit: 0xFF+1 -> 0x00, 0xFF+2 -> 0x01).
- Vector latency: 1 cycle from RST_VEC or INT_VEC to the first valid fetch.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs fetch_cnt[15:0] and stall_cnt[15:0], both reset to 0.
- fetch_cnt increments on each non-stalled RUN cycle.
- stall_cnt increments on each f_stall=1 cycle.
- Both saturate at 0xFFFF.
When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: state enum (RST_VEC, RUN, INT_VEC), instruction length constants (ILEN_1=1, ILEN_2=2).
- Optional sub-module fetch_perf_cnt holds the saturating counters, instantiated only under the macro.
- The next-PC mux and FSM stay in fetch_unit.

Test Plan:
- Reset low 2 cycles, mem[0]=0x10 -> pc=0x00, fetch_valid=0; one cycle after release pc=0x10, fetch_valid=1.
- RUN at 0x10, imm_en pattern 0,1,0 -> pc 0x11, 0x13, 0x14; pc=0xFF with imm_en=1 -> 0x01.
- pc=0x20, branch_taken=1, target=0x40, f_stall=1 -> pc stays 0x20; stall released -> pc=0x40.
- pc=0x30, imm_en=1, intr_req=1, mem[1]=0x80 -> intr_ack pulse, ret_pc=0x32, pc=0x01, then pc=0x80 and fetch_valid=1; intr_req held 1 extra cycle -> exactly one ack.
- Branch to 0x55 and intr_req in the same cycle -> ret_pc=0x55; reset asserted during INT_VEC -> pc=0x00, state RST_VEC, intr_ack=0.
- With FETCH_PERF_CNT_EN: 5 run cycles + 3 stall cycles -> fetch_cnt=5, stall_cnt=3; preload to 0xFFFF -> counters hold 0xFFFF.
